// File: rtl/softmax_q88_pkg.sv
// softmax_q88_pkg: shared Q8.8 constants and shift-direction type
package softmax_q88_pkg;
  localparam int Q88_W = 16;
  localparam int Q88_FRAC = 8;
  localparam logic [Q88_W-1:0] Q88_MAX = 16'hFFFF;
  localparam logic [Q88_W-1:0] Q88_ONE = 16'h0100;
  typedef enum logic {SH_LEFT = 1'b0, SH_RIGHT = 1'b1} shift_dir_e;
endpackage

// File: rtl/pow2_shifter.sv
// pow2_shifter: bidirectional barrel shift of the Q1.8 mantissa with range clamping
module pow2_shifter
  import softmax_q88_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic [Q88_FRAC:0]  m,
  input  logic [4:0]         mag,
  input  shift_dir_e         dir,
  input  logic               ovf,
  input  logic               unf,
  output logic [Q88_W-1:0]   res
);
  logic [24:0]       left;
  logic [Q88_FRAC:0] right;
  // mag=16 on a left shift pushes every mantissa bit out of the low 16 bits
  always_comb begin
    left = {16'b0, m} << mag;
    right = m >> mag;
    res = unf ? '0 : (ovf && SAT_EN) ? Q88_MAX : (dir == SH_LEFT) ? left[Q88_W-1:0] : {7'b0, right};
  end
endmodule

// File: rtl/stage3_pow2_approx.sv
// stage3_pow2_approx: three-stage pipelined 2^x approximation in Q8.8
module stage3_pow2_approx
  import softmax_q88_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_in,
  input  logic [Q88_W-1:0] in_0,
  input  logic [Q88_W-1:0] in_1,
  output logic             valid_out,
  output logic [Q88_W-1:0] pow_out,
  output logic [Q88_W-1:0] in_1_bypass
);
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [Q88_W-1:0] x1_q, x1_d, sb1_q, sb1_d, sb2_q, sb2_d, sb3_q, sb3_d, res3_q, res3_d;
  logic [Q88_FRAC:0] m2_q, m2_d;
  logic [4:0]       mag2_q, mag2_d;
  shift_dir_e       dir2_q, dir2_d;
  logic             ovf2_q, ovf2_d, unf2_q, unf2_d;
  logic [7:0]       i;
  logic [3:0]       neg_lo;
  logic [Q88_W-1:0] res;

  pow2_shifter #(.SAT_EN(SAT_EN)) u_shift (
    .m   (m2_q),
    .mag (mag2_q),
    .dir (dir2_q),
    .ovf (ovf2_q),
    .unf (unf2_q),
    .res (res)
  );

  // next-state for all stages; en low holds every register including valids
  always_comb begin
    i = x1_q[15:8];
    neg_lo = -i[3:0];
    v1_d = en ? valid_in : v1_q;
    x1_d = en ? in_0 : x1_q;
    sb1_d = en ? in_1 : sb1_q;
    v2_d = en ? v1_q : v2_q;
    sb2_d = en ? sb1_q : sb2_q;
    m2_d = en ? {1'b1, x1_q[7:0]} : m2_q;
    mag2_d = en ? (i[7] ? {1'b0, neg_lo} : (|i[6:4] ? 5'd16 : i[4:0])) : mag2_q;
    dir2_d = en ? (i[7] ? SH_RIGHT : SH_LEFT) : dir2_q;
    ovf2_d = en ? (~i[7] & (|i[6:3])) : ovf2_q;
    unf2_d = en ? (i[7] & ~(&i[6:3])) : unf2_q;
    v3_d = en ? v2_q : v3_q;
    sb3_d = en ? sb2_q : sb3_q;
    res3_d = en ? res : res3_q;
  end

  // stage registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      x1_q <= '0;
      sb1_q <= '0;
      v2_q <= 1'b0;
      sb2_q <= '0;
      m2_q <= '0;
      mag2_q <= '0;
      dir2_q <= SH_LEFT;
      ovf2_q <= 1'b0;
      unf2_q <= 1'b0;
      v3_q <= 1'b0;
      sb3_q <= '0;
      res3_q <= '0;
    end else begin
      v1_q <= v1_d;
      x1_q <= x1_d;
      sb1_q <= sb1_d;
      v2_q <= v2_d;
      sb2_q <= sb2_d;
      m2_q <= m2_d;
      mag2_q <= mag2_d;
      dir2_q <= dir2_d;
      ovf2_q <= ovf2_d;
      unf2_q <= unf2_d;
      v3_q <= v3_d;
      sb3_q <= sb3_d;
      res3_q <= res3_d;
    end
  end

  assign valid_out = v3_q;
  assign pow_out = res3_q;
  assign in_1_bypass = sb3_q;
endmodule

// File: tb/tb_stage3_pow2_approx.sv
// tb_stage3_pow2_approx: directed-vector bench for stage3_pow2_approx
module tb_stage3_pow2_approx;
  logic        clk = 1'b0;
  logic        rst_n, en, valid_in;
  logic [15:0] in_0, in_1;
  logic        valid_out, valid_out_n;
  logic [15:0] pow_out, pow_out_n, in_1_bypass, in_1_bypass_n;
  int          n_tests = 0;
  int          n_fail = 0;

  stage3_pow2_approx #(.SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .in_0(in_0), .in_1(in_1),
    .valid_out(valid_out), .pow_out(pow_out), .in_1_bypass(in_1_bypass)
  );

  stage3_pow2_approx #(.SAT_EN(1'b0)) dut_nosat (
    .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .in_0(in_0), .in_1(in_1),
    .valid_out(valid_out_n), .pow_out(pow_out_n), .in_1_bypass(in_1_bypass_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] sb);
    valid_in = v;
    in_0 = x;
    in_1 = sb;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    n_tests += 3;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_out); end
    if (pow_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pow got %h want 0000", pow_out); end
    if (in_1_bypass !== 16'h0000) begin n_fail++; $display("FAIL reset_sb got %h want 0000", in_1_bypass); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] xs [4] = '{16'h0000, 16'h0180, 16'hFF00, 16'hFE80};
    logic [15:0] ex [4] = '{16'h0100, 16'h0300, 16'h0080, 16'h0060};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, xs[k], 16'hB000 + 16'(k));
      tick();
      drive(1'b0, 16'h0000, 16'h0000);
      tick();
      n_tests++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_early[%0d] valid got %b want 0", k, valid_out); end
      tick();
      n_tests += 3;
      if (valid_out !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d] got %b want 1", k, valid_out); end
      if (pow_out !== ex[k]) begin n_fail++; $display("FAIL basic_pow[%0d] x=%h got %h want %h", k, xs[k], pow_out, ex[k]); end
      if (in_1_bypass !== 16'hB000 + 16'(k)) begin n_fail++; $display("FAIL basic_sb[%0d] got %h want %h", k, in_1_bypass, 16'hB000 + 16'(k)); end
    end
  endtask

  task automatic test_range();
    logic [15:0] xs [6] = '{16'h07FF, 16'h0800, 16'h08FF, 16'hF800, 16'hF700, 16'h8000};
    logic [15:0] es [6] = '{16'hFF80, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
    logic [15:0] en0 [6] = '{16'hFF80, 16'h0000, 16'hFF00, 16'h0001, 16'h0000, 16'h0000};
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, xs[k], 16'hD000 + 16'(k));
      tick();
      drive(1'b0, 16'h0000, 16'h0000);
      tick(); tick();
      n_tests += 3;
      if (valid_out !== 1'b1 || valid_out_n !== 1'b1) begin n_fail++; $display("FAIL range_valid[%0d] got %b/%b want 1/1", k, valid_out, valid_out_n); end
      if (pow_out !== es[k]) begin n_fail++; $display("FAIL range_sat[%0d] x=%h got %h want %h", k, xs[k], pow_out, es[k]); end
      if (pow_out_n !== en0[k]) begin n_fail++; $display("FAIL range_nosat[%0d] x=%h got %h want %h", k, xs[k], pow_out_n, en0[k]); end
    end
  endtask

  task automatic test_stall();
    logic [15:0] got_p[$], got_s[$];
    logic        hv;
    logic [15:0] hp, hs;
    logic [15:0] ep [4] = '{16'h0100, 16'h0200, 16'h0400, 16'h0800};
    for (int c = 0; c < 10; c++) begin
      en = !(c == 2 || c == 3);
      if (c < 2) drive(1'b1, 16'(c) << 8, 16'hA000 + 16'(c));
      else if (c < 4) drive(1'b1, 16'h0700, 16'hEEEE);
      else if (c < 6) drive(1'b1, 16'(c - 2) << 8, 16'hA000 + 16'(c - 2));
      else drive(1'b0, 16'h0000, 16'h0000);
      hv = valid_out; hp = pow_out; hs = in_1_bypass;
      tick();
      if (!en) begin
        n_tests++;
        if (valid_out !== hv || pow_out !== hp || in_1_bypass !== hs)
          begin n_fail++; $display("FAIL stall_hold[%0d] got %b/%h/%h want %b/%h/%h", c, valid_out, pow_out, in_1_bypass, hv, hp, hs); end
      end else if (valid_out) begin
        got_p.push_back(pow_out);
        got_s.push_back(in_1_bypass);
      end
    end
    en = 1'b1;
    n_tests++;
    if (got_p.size() != 4) begin n_fail++; $display("FAIL stall_count got %0d want 4", got_p.size()); end
    for (int k = 0; k < 4 && k < got_p.size(); k++) begin
      n_tests += 2;
      if (got_p[k] !== ep[k]) begin n_fail++; $display("FAIL stall_pow[%0d] got %h want %h", k, got_p[k], ep[k]); end
      if (got_s[k] !== 16'hA000 + 16'(k)) begin n_fail++; $display("FAIL stall_sb[%0d] got %h want %h", k, got_s[k], 16'hA000 + 16'(k)); end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h0100, 16'h5A50 + 16'(k));
      tick();
    end
    drive(1'b0, 16'h0000, 16'h0000);
    n_tests++;
    if (valid_out !== 1'b1) begin n_fail++; $display("FAIL areset_pre valid got %b want 1", valid_out); end
    #2 rst_n = 1'b0;
    #1;
    n_tests += 3;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", valid_out); end
    if (pow_out !== 16'h0000) begin n_fail++; $display("FAIL areset_pow got %h want 0000", pow_out); end
    if (in_1_bypass !== 16'h0000) begin n_fail++; $display("FAIL areset_sb got %h want 0000", in_1_bypass); end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL areset_stale[%0d] valid got %b want 0", k, valid_out); end
    end
  endtask

  task automatic test_bubbles();
    en = 1'b1;
    for (int n = 0; n < 13; n++) begin
      if (n < 10) drive(n % 2 == 0, 16'(n % 8) << 8, 16'hC000 + 16'(n));
      else drive(1'b0, 16'h0000, 16'h0000);
      tick();
      if (n >= 2) begin
        int k = n - 2;
        logic ev = (k < 10) && (k % 2 == 0);
        n_tests++;
        if (valid_out !== ev) begin n_fail++; $display("FAIL bubble_valid[%0d] got %b want %b", k, valid_out, ev); end
        if (ev) begin
          n_tests += 2;
          if (in_1_bypass !== 16'hC000 + 16'(k)) begin n_fail++; $display("FAIL bubble_sb[%0d] got %h want %h", k, in_1_bypass, 16'hC000 + 16'(k)); end
          if (pow_out !== (16'h0100 << (k % 8))) begin n_fail++; $display("FAIL bubble_pow[%0d] got %h want %h", k, pow_out, 16'h0100 << (k % 8)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_stall();
    test_async_reset();
    test_bubbles();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
